// File: rtl/fpu_divider_if.sv
// Handshake and data bundle for fpu_divider.
//   master: drives start, a, b; observes busy, done, result, div_by_zero
//   slave : the divider side of the same signals
interface fpu_divider_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_by_zero;

  modport master (output start, a, b, input busy, done, result, div_by_zero);
  modport slave  (input start, a, b, output busy, done, result, div_by_zero);
endinterface

// File: rtl/fpu_divider.sv
// Multi-cycle IEEE-754 single-precision divider (restoring mantissa division,
// truncating rounding, overflow to infinity, underflow to zero).
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - fpu_divider_if.slave: start/a/b in, busy/done/result/div_by_zero out
// Optional feature: define FPU_DIV_SPECIAL_EN to resolve NaN/inf/zero operands
// in one cycle (bypassing CALC) and report div_by_zero. Without it every operand
// takes the 26-cycle CALC path with an implicit leading 1 and div_by_zero is 0.
module fpu_divider (
  input  logic          clk,
  input  logic          rst_n,
  fpu_divider_if.slave  bus
);

  localparam int unsigned MW = 24;  // mantissa width including hidden bit
  localparam int unsigned QW = 25;  // quotient bits produced
  localparam int unsigned CW = 5;   // iteration counter width
  localparam int unsigned EW = 10;  // signed exponent working width
  localparam logic [CW-1:0] LAST_ITER = CW'(QW - 1);
  localparam logic [31:0]   QNAN      = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, CALC, NORM} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         iter_q;
  logic [MW:0]           rem_q;
  logic [MW-1:0]         dvs_q;
  logic [QW-1:0]         quo_q;
  logic signed [EW-1:0]  exp_q;
  logic                  sign_q;
  logic                  spec_q;
  logic [31:0]           spec_res_q;
  logic                  spec_dz_q;
  logic                  busy_q;
  logic                  done_q;
  logic [31:0]           result_q;
  logic                  dz_q;

  logic                  special_c;
  logic [31:0]           spec_res_c;
  logic                  spec_dz_c;
  logic                  ge_c;
  logic [MW-1:0]         rem_sub_c;
  logic signed [EW-1:0]  exp_n_c;
  logic [22:0]           man_c;
  logic [31:0]           norm_res_c;

`ifdef FPU_DIV_SPECIAL_EN
  // Special-operand classification, resolved in priority order.
  logic a_ff, b_ff, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_c;
  assign a_ff   = &bus.a[30:23];
  assign b_ff   = &bus.b[30:23];
  assign a_nan  = a_ff & (|bus.a[22:0]);
  assign b_nan  = b_ff & (|bus.b[22:0]);
  assign a_inf  = a_ff & ~(|bus.a[22:0]);
  assign b_inf  = b_ff & ~(|bus.b[22:0]);
  assign a_zero = (bus.a[30:23] == 8'h00);
  assign b_zero = (bus.b[30:23] == 8'h00);
  assign s_c    = bus.a[31] ^ bus.b[31];

  always_comb begin
    special_c  = 1'b1;
    spec_dz_c  = 1'b0;
    spec_res_c = QNAN;
    if (a_nan || b_nan) begin
      spec_res_c = QNAN;
    end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res_c = QNAN;
    end else if (b_zero) begin
      spec_res_c = {s_c, 8'hFF, 23'd0};
      spec_dz_c  = 1'b1;
    end else if (a_inf) begin
      spec_res_c = {s_c, 8'hFF, 23'd0};
    end else if (b_inf || a_zero) begin
      spec_res_c = {s_c, 31'd0};
    end else begin
      special_c  = 1'b0;
    end
  end
`else
  assign special_c  = 1'b0;
  assign spec_res_c = 32'h0;
  assign spec_dz_c  = 1'b0;
`endif

  // Restoring step: subtract when the partial remainder covers the divisor.
  assign ge_c      = (rem_q >= {1'b0, dvs_q});
  assign rem_sub_c = ge_c ? MW'(rem_q - {1'b0, dvs_q}) : rem_q[MW-1:0];

  // Normalisation and range clamp of the finished quotient.
  assign exp_n_c = quo_q[QW-1] ? exp_q : exp_q - 10'sd1;
  assign man_c   = quo_q[QW-1] ? quo_q[23:1] : quo_q[22:0];

  always_comb begin
    norm_res_c = {sign_q, exp_n_c[7:0], man_c};
    if (exp_n_c >= 10'sd255) begin
      norm_res_c = {sign_q, 8'hFF, 23'd0};
    end else if (exp_n_c <= 10'sd0) begin
      norm_res_c = {sign_q, 31'd0};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = special_c ? NORM : CALC;
      CALC:    if (iter_q == LAST_ITER) state_d = NORM;
      NORM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q     <= '0;
      rem_q      <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_dz_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
      dz_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      busy_q <= (state_d != IDLE);
      case (state_q)
        IDLE: if (bus.start) begin
          sign_q     <= bus.a[31] ^ bus.b[31];
          exp_q      <= $signed({2'b00, bus.a[30:23]}) - $signed({2'b00, bus.b[30:23]}) + 10'sd127;
          rem_q      <= {2'b01, bus.a[22:0]};
          dvs_q      <= {1'b1, bus.b[22:0]};
          quo_q      <= '0;
          iter_q     <= '0;
          spec_q     <= special_c;
          spec_res_q <= spec_res_c;
          spec_dz_q  <= spec_dz_c;
        end
        CALC: begin
          quo_q  <= {quo_q[QW-2:0], ge_c};
          rem_q  <= {rem_sub_c, 1'b0};
          iter_q <= iter_q + CW'(1);
        end
        NORM: begin
          done_q   <= 1'b1;
          result_q <= spec_q ? spec_res_q : norm_res_c;
          dz_q     <= spec_q & spec_dz_q;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.div_by_zero = dz_q;

endmodule

// File: tb/tb_fpu_divider.sv
// Scoreboard bench for fpu_divider: directed and random operands, expected
// results from an arithmetic reference model, checked by an independent monitor.
module tb_fpu_divider;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_divider_if bus ();
  fpu_divider dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic [31:0] res;
    logic        dz;
    logic        spec;
  } mres_t;

  typedef struct {
    logic [31:0] res;
    logic        dz;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] last_res = 32'h0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: quotient = floor(ma * 2^24 / mb), exponent ea - eb + 127.
  function automatic mres_t model(input logic [31:0] a, input logic [31:0] b);
    mres_t           r;
    logic            s;
    int              ea, eb, e;
    longint unsigned ma, mb, q, man;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    r.spec = 1'b0;
    r.dz   = 1'b0;
    r.res  = 32'h0;
`ifdef FPU_DIV_SPECIAL_EN
    begin
      bit an, bn, ai, bi, az, bz;
      an = (ea == 255) && (a[22:0] != 0);
      bn = (eb == 255) && (b[22:0] != 0);
      ai = (ea == 255) && (a[22:0] == 0);
      bi = (eb == 255) && (b[22:0] == 0);
      az = (ea == 0);
      bz = (eb == 0);
      r.spec = 1'b1;
      if (an || bn)                        r.res = 32'h7FC00000;
      else if ((az && bz) || (ai && bi))   r.res = 32'h7FC00000;
      else if (bz) begin                   r.res = {s, 8'hFF, 23'd0}; r.dz = 1'b1; end
      else if (ai)                         r.res = {s, 8'hFF, 23'd0};
      else if (bi || az)                   r.res = {s, 31'd0};
      else                                 r.spec = 1'b0;
      if (r.spec) return r;
    end
`endif
    q = (ma << 24) / mb;
    e = ea - eb + 127;
    if (q >= (64'd1 << 24)) man = q >> 1;
    else begin man = q; e--; end
    if (e >= 255)     r.res = {s, 8'hFF, 23'd0};
    else if (e <= 0)  r.res = {s, 31'd0};
    else              r.res = {s, 8'(e), 23'(man)};
    return r;
  endfunction

  // Monitor: pops the scoreboard on every done, checks hold otherwise.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n === 1'b1) begin
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("result", bus.result, e.res);
          chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dz));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("busy_in_done", 32'(bus.busy), 32'd0);
        end
        last_res = bus.result;
      end else begin
        chk("result_hold", bus.result, last_res);
      end
    end
  end

  // Entered at a negedge; returns at the negedge where done is seen, so the
  // next call asserts start inside the done cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit pulse_mid);
    mres_t m;
    int    k;
    m = model(a, b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    sb.push_back('{m.res, m.dz, cyc + 1 + (m.spec ? 1 : 26)});
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    chk("busy_after_start", 32'(bus.busy), 32'd1);
    k = 0;
    while (bus.done !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
      bus.start = (pulse_mid && k == 4);
      bus.a     = $urandom;
      bus.b     = $urandom;
    end
    bus.start = 1'b0;
    if (bus.done !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done for a=%h b=%h", a, b);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 32'h0;
    bus.b     = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_result", bus.result, 32'h0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(32'h40C00000, 32'h40000000, 1'b0);
    run_op(32'h3F800000, 32'h40400000, 1'b0);
    run_op(32'hC0F00000, 32'h40200000, 1'b1);
    run_op(32'h7F000000, 32'h00800000, 1'b0);
    run_op(32'h00800000, 32'h7F000000, 1'b0);
    run_op(32'hBF800000, 32'h3F800000, 1'b0);
`ifdef FPU_DIV_SPECIAL_EN
    run_op(32'h3F800000, 32'h00000000, 1'b0);
    run_op(32'h7FC00001, 32'h3F800000, 1'b0);
    run_op(32'h00000000, 32'h80000000, 1'b0);
    run_op(32'hFF800000, 32'h7F800000, 1'b0);
    run_op(32'hFF800000, 32'h40000000, 1'b0);
    run_op(32'h40000000, 32'hFF800000, 1'b0);
    run_op(32'h80000000, 32'h40000000, 1'b0);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        ra[30:23] = 8'(100 + $urandom_range(0, 55));
        rb[30:23] = 8'(100 + $urandom_range(0, 55));
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(ra, rb, 1'b0);
    end

    // Abort a 6.0/2.0 operation with reset at T0+10.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'h40C00000;
    bus.b     = 32'h40000000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_result", bus.result, 32'h0);
    chk("abort_dz", 32'(bus.div_by_zero), 32'd0);
    last_res = 32'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("idle_after_abort", 32'(bus.busy), 32'd0);
    run_op(32'h40C00000, 32'h40000000, 1'b0);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
